// File: rtl/load_align_pkg.sv
// Shared length codes for memory access sizes.
package load_align_pkg;
  localparam logic [1:0] MA_LEN_1B = 2'd0;
  localparam logic [1:0] MA_LEN_2B = 2'd1;
  localparam logic [1:0] MA_LEN_4B = 2'd2;
endpackage

// File: rtl/load_align_if.sv
// Load request descriptor in, aligned/extended load result out.
interface load_align_if;
  logic        load;
  logic        stall;
  logic [1:0]  len;
  logic        uns;
  logic [1:0]  addr_lo;
  logic        flush;
  logic [31:0] rdata;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output load, stall, len, uns, addr_lo, flush, rdata,
    input  rd_data, rd_valid
  );

  modport slave (
    input  load, stall, len, uns, addr_lo, flush, rdata,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/load_align.sv
// Aligns and sign/zero-extends load data, merging two word reads for misaligned loads.
// Latency: 1 cycle aligned, 2 cycles misaligned; no backpressure (upstream stall splits accesses).
module load_align
  import load_align_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  load_align_if.slave  bus
);

  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_HI, K_LO} kind_t;

  kind_t       kind_q, kind_d;
  logic [1:0]  len_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] hi_q;

  logic [63:0] src;
  logic [4:0]  sh;
  logic [31:0] raw;
  logic [31:0] ext;
  logic        sgn;

  // Flush drops the HI history too, so the next access can never pair as LO.
  always_comb begin
    kind_d = K_NONE;
    if (bus.flush || !bus.load) begin
      kind_d = K_NONE;
    end else if (bus.stall) begin
      kind_d = K_HI;
    end else if (kind_q == K_HI) begin
      kind_d = K_LO;
    end else begin
      kind_d = K_SINGLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q <= K_NONE;
      len_q  <= 2'd0;
      uns_q  <= 1'b0;
      off_q  <= 2'd0;
      hi_q   <= 32'd0;
    end else begin
      kind_q <= kind_d;
      len_q  <= bus.load ? bus.len     : 2'd0;
      uns_q  <= bus.load ? bus.uns     : 1'b0;
      off_q  <= bus.load ? bus.addr_lo : 2'd0;
      if (kind_q == K_HI) begin
        hi_q <= bus.rdata;
      end
    end
  end

  always_comb begin
    src = (kind_q == K_LO) ? {hi_q, bus.rdata} : {32'd0, bus.rdata};
    sh  = {off_q, 3'b000};
    raw = 32'(src >> sh);
    ext = raw;
    sgn = 1'b0;
    case (len_q)
      MA_LEN_1B: begin
        sgn = ~uns_q & raw[7];
        ext = {{24{sgn}}, raw[7:0]};
      end
      MA_LEN_2B: begin
        sgn = ~uns_q & raw[15];
        ext = {{16{sgn}}, raw[15:0]};
      end
      MA_LEN_4B: ext = raw;
      default:   ext = raw;
    endcase
  end

  always_comb begin
    bus.rd_valid = ((kind_q == K_SINGLE) || (kind_q == K_LO)) && !bus.flush;
    bus.rd_data  = bus.rd_valid ? ext : 32'd0;
  end

endmodule

// File: tb/tb_load_align.sv
// Directed bench for load_align: stimulus queues expected results, a monitor checks each output pulse.
module tb_load_align;
  import load_align_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];

  load_align_if bus();

  load_align u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic ld, input logic st, input logic [1:0] ln,
                       input logic u, input logic [1:0] off, input logic fl,
                       input logic [31:0] rd);
    bus.load    = ld;
    bus.stall   = st;
    bus.len     = ln;
    bus.uns     = u;
    bus.addr_lo = off;
    bus.flush   = fl;
    bus.rdata   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] rd);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, rd);
  endtask

  task automatic expect_at_next(input logic [31:0] d);
    exp_q.push_back('{cyc + 1, d});
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid cyc=%0d rd_data=%h required no result", cyc, bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rd_data !== e.dat || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL result cyc=%0d rd_data=%h required cyc=%0d rd_data=%h",
                     cyc, bus.rd_data, e.cyc, e.dat);
          end
        end
      end else begin
        if (bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_zero cyc=%0d rd_valid=%b rd_data=%h required 0/0",
                   cyc, bus.rd_valid, bus.rd_data);
        end
      end
    end
  endtask

  task automatic run_stim();
    bus.load = 1'b0; bus.stall = 1'b0; bus.len = 2'd0; bus.uns = 1'b0;
    bus.addr_lo = 2'd0; bus.flush = 1'b0; bus.rdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // signed byte, offset 3
    expect_at_next(32'hFFFFFF80);
    drive(1, 0, MA_LEN_1B, 0, 2'd3, 0, 32'h0);
    idle(32'h80123456);

    // misaligned word, offset 2
    drive(1, 1, MA_LEN_4B, 0, 2'd2, 0, 32'h0);
    expect_at_next(32'h2211DDCC);
    drive(1, 0, MA_LEN_4B, 0, 2'd2, 0, 32'h44332211);
    idle(32'hDDCCBBAA);

    // misaligned halfword, offset 3, signed then unsigned
    drive(1, 1, MA_LEN_2B, 0, 2'd3, 0, 32'h0);
    expect_at_next(32'hFFFFF180);
    drive(1, 0, MA_LEN_2B, 0, 2'd3, 0, 32'h000000F1);
    idle(32'h80000000);
    drive(1, 1, MA_LEN_2B, 1, 2'd3, 0, 32'h0);
    expect_at_next(32'h0000F180);
    drive(1, 0, MA_LEN_2B, 1, 2'd3, 0, 32'h000000F1);
    idle(32'h80000000);

    // back-to-back: aligned lw, misaligned lw, aligned lhu
    expect_at_next(32'hA1B2C3D4);
    drive(1, 0, MA_LEN_4B, 0, 2'd0, 0, 32'h0);
    drive(1, 1, MA_LEN_4B, 0, 2'd1, 0, 32'hA1B2C3D4);
    expect_at_next(32'h44556677);
    drive(1, 0, MA_LEN_4B, 0, 2'd1, 0, 32'h11223344);
    expect_at_next(32'h00009ABC);
    drive(1, 0, MA_LEN_2B, 1, 2'd2, 0, 32'h55667788);
    idle(32'h9ABCDEF0);

    // reset during the HI data cycle, then a load right after reset
    drive(1, 1, MA_LEN_4B, 0, 2'd2, 0, 32'h0);
    rst = 1'b1;
    drive(1, 0, MA_LEN_4B, 0, 2'd2, 0, 32'h44332211);
    rst = 1'b0;
    expect_at_next(32'h12345678);
    drive(1, 0, MA_LEN_4B, 0, 2'd0, 0, 32'hDDCCBBAA);
    idle(32'h12345678);

    // flush during the HI data cycle, next load must not merge
    drive(1, 1, MA_LEN_4B, 0, 2'd2, 0, 32'h0);
    drive(1, 0, MA_LEN_4B, 0, 2'd2, 1, 32'h44332211);
    expect_at_next(32'h000000AB);
    drive(1, 0, MA_LEN_1B, 1, 2'd1, 0, 32'hDDCCBBAA);
    idle(32'h0000AB00);

    // flush in a SINGLE data cycle suppresses the result
    drive(1, 0, MA_LEN_4B, 0, 2'd0, 0, 32'h0);
    drive(0, 0, MA_LEN_4B, 0, 2'd0, 1, 32'hFFFFFFFF);
    idle(32'h0);

    // abandoned HI, then an aligned load returns unmerged data
    drive(1, 1, MA_LEN_4B, 0, 2'd2, 0, 32'h0);
    idle(32'h44332211);
    expect_at_next(32'hCAFEF00D);
    drive(1, 0, MA_LEN_4B, 0, 2'd0, 0, 32'h0);
    idle(32'hCAFEF00D);

    // invalid len code behaves as a word; aligned signed half; unsigned byte
    expect_at_next(32'h80000001);
    drive(1, 0, 2'd3, 0, 2'd0, 0, 32'h0);
    expect_at_next(32'hFFFF8001);
    drive(1, 0, MA_LEN_2B, 0, 2'd2, 0, 32'h80000001);
    expect_at_next(32'h000000FE);
    drive(1, 0, MA_LEN_1B, 1, 2'd0, 0, 32'h8001ABCD);
    idle(32'h000000FE);

    repeat (4) idle(32'h0);
  endtask

  initial begin
    fork
      run_stim();
      monitor_loop();
    join_any
    disable fork;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_results outstanding=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_align.md
LOAD_ALIGN -- requirements
Module: load_align

Interface
REQ-001 SHALL have no parameters; length codes are MA_LEN_1B, MA_LEN_2B and MA_LEN_4B from the shared define header.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: load  in  1  load access issued to memory this cycle.
REQ-005 SHALL have port: stall  in  1  high when the issued access is the first (upper-word) half of a misaligned load.
REQ-006 SHALL have port: len  in  2  access length code.
REQ-007 SHALL have port: uns  in  1  zero-extend (1) or sign-extend (0) the result.
REQ-008 SHALL have port: addr_lo  in  2  byte offset of the original load address.
REQ-009 SHALL have port: flush  in  1  discard all pending load state.
REQ-010 SHALL have port: rdata  in  32  memory read data, one cycle after the address was issued.
REQ-011 SHALL have port: rd_data  out  32  aligned, extended load result.
REQ-012 SHALL have port: rd_valid  out  1  rd_data holds a completed load this cycle.

Function
REQ-013 SHALL register, at each rising edge, a descriptor for the access issued that cycle: kind, len, uns and addr_lo.
- kind values: NONE, SINGLE, HI, LO.
REQ-014 SHALL assign the descriptor kind from the inputs and the previous descriptor kind:
- load=0 -> NONE.
- load=1 and stall=1 -> HI.
- load=1, stall=0, previous kind HI -> LO.
- otherwise (load=1, stall=0) -> SINGLE.
REQ-015 SHALL interpret rdata each cycle against the descriptor registered at the previous edge.
REQ-016 SHALL, for a HI descriptor, capture rdata into the 32-bit upper-word register hi_q and hold rd_valid=0.
REQ-017 SHALL, for a SINGLE descriptor, form the raw value as rdata shifted right by addr_lo*8.
REQ-018 SHALL, for a LO descriptor, form the raw value as the 64-bit concatenation {hi_q, rdata} shifted right by addr_lo*8, keeping bits [31:0].
REQ-019 SHALL select the low 8, 16 or 32 bits of the raw value per len.
REQ-020 SHALL extend the selected value to 32 bits: zero-extend when uns=1, sign-extend when uns=0; the 4B length ignores uns.
REQ-021 SHALL assert rd_valid combinationally in the same cycle that rdata is consumed for SINGLE or LO, giving these latencies:
- aligned load: result 1 cycle after issue.
- misaligned load: result 2 cycles after the first issue.
REQ-022 SHALL drive rd_data=0 whenever rd_valid=0.
REQ-023 SHALL support back-to-back loads with no bubble, including a misaligned load directly after another load.
REQ-024 SHALL, if a HI descriptor is not followed by a load in the next cycle:
- discard hi_q;
- produce no result;
- register the next access as SINGLE or NONE.
REQ-025 SHALL ignore stall, len, uns and addr_lo when load=0.
REQ-026 SHALL treat an invalid len code as MA_LEN_4B.
REQ-027 SHALL, when flush=1 at an edge:
- register the descriptor as NONE regardless of load;
- clear the previous-kind history so that the next access is not classified LO;
- force rd_valid=0 in the flush cycle.

Reset
REQ-028 SHALL, while rst=1, asynchronously set the descriptor kind to NONE and clear hi_q, len, uns and addr_lo to 0, so that rd_valid=0 and rd_data=0.
REQ-029 SHALL drop a load that was mid-operation (HI captured, LO pending) on reset and produce no result after rst deasserts.
REQ-030 SHALL accept a new load in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover a signed byte load: load, len=1B, uns=0, addr_lo=3; next cycle rdata=0x80123456 -> rd_valid=1, rd_data=0xFFFFFF80.
REQ-032 SHALL cover a misaligned word load at addr_lo=2, with HI cycle rdata=0x44332211 and LO cycle rdata=0xDDCCBBAA:
- rd_valid=0 in the HI data cycle;
- next cycle rd_valid=1, rd_data=0x2211DDCC.
REQ-033 SHALL cover a misaligned halfword load at addr_lo=3, with hi rdata=0x000000F1 and lo rdata=0x80000000:
- uns=0 -> rd_data=0xFFFFF180;
- repeated with uns=1 -> rd_data=0x0000F180.
REQ-034 SHALL cover back-to-back loads: aligned lw at offset 0, then misaligned lw, then aligned lhu in consecutive cycles -> three rd_valid pulses at cycles 1, 3 and 4 with the correct data.
REQ-035 SHALL cover interruption of a misaligned load:
- assert rst in the HI data cycle -> rd_valid stays 0 through the would-be LO cycle;
- repeat with flush instead of rst -> same response.
REQ-036 SHALL cover an abandoned HI: HI issue followed by load=0 -> no rd_valid pulse, and a following aligned load returns its data unmerged.
